// File: rtl/spi_tgt_core.sv
// SPI target engine: oversamples SCK/NSS/MOSI in the clk_i domain, shifts 8..32-bit frames
// in any CPOL/CPHA mode and exchanges words through valid/ready handshakes.
module spi_tgt_core (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic        cpol_i,
  input  logic        cpha_i,
  input  logic        lsb_i,
  input  logic [1:0]  dtb_i,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  input  logic [31:0] tx_data_i,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output logic [31:0] rx_data_o,
  output logic        busy_o,
  output logic        udr_o,
  output logic        ovr_o,
  input  logic        spi_sck_i,
  input  logic        spi_nss_i,
  input  logic        spi_mosi_i,
  output logic        spi_miso_o,
  output logic        spi_miso_en_o
);

  // Handshakes: a word moves on tx or rx only in a cycle where valid and ready are both 1;
  // tx_ready_o is a combinational response to the load event and never waits on itself.
  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t      state;
  logic        sck_s1, sck_s2, sck_h;
  logic        nss_s1, nss_s2, nss_h;
  logic        mosi_s1, mosi_s2;
  logic [1:0]  settle;
  logic        armed;
  logic [31:0] tx_word;
  logic [31:0] rx_word;
  logic [5:0]  cnt;
  logic [4:0]  idx;
  logic        done;

  logic        sck_rise, sck_fall, nss_fall, nss_rise;
  logic        lead, trail, is_active;
  logic        start, stop, smp, shf, load, complete;
  logic [4:0]  n_m1;
  logic [5:0]  n_bits, cnt_inc;
  logic [4:0]  rx_pos, tx_pos, idx_n;
  logic [31:0] rx_next, word_n;
  logic        miso_n;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sck_s1  <= 1'b0;
      sck_s2  <= 1'b0;
      sck_h   <= 1'b0;
      nss_s1  <= 1'b1;
      nss_s2  <= 1'b1;
      nss_h   <= 1'b1;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
      settle  <= 2'd0;
      armed   <= 1'b0;
    end else begin
      sck_s1  <= spi_sck_i;
      sck_s2  <= sck_s1;
      sck_h   <= sck_s2;
      nss_s1  <= spi_nss_i;
      nss_s2  <= nss_s1;
      nss_h   <= nss_s2;
      mosi_s1 <= spi_mosi_i;
      mosi_s2 <= mosi_s1;
      if (settle != 2'd3) settle <= settle + 2'd1;
      // A frame may only start after NSS has really been seen high, so a reset in the
      // middle of a held-low NSS cannot fake a falling edge from the reset values.
      if (settle == 2'd3 && nss_s2) armed <= 1'b1;
    end
  end

  always_comb begin
    sck_rise  = sck_s2 & ~sck_h;
    sck_fall  = ~sck_s2 & sck_h;
    nss_fall  = ~nss_s2 & nss_h;
    nss_rise  = nss_s2 & ~nss_h;
    lead      = cpol_i ? sck_fall : sck_rise;
    trail     = cpol_i ? sck_rise : sck_fall;
    is_active = (state == ACTIVE);
    start     = ~is_active & en_i & armed & nss_fall;
    stop      = is_active & (nss_rise | ~en_i);
    smp       = is_active & ~stop & (cpha_i ? trail : lead);
    shf       = is_active & ~stop & (cpha_i ? lead : trail);
    load      = start | (shf & done);
    n_m1      = {dtb_i, 3'b111};
    n_bits    = {1'b0, n_m1} + 6'd1;
    cnt_inc   = cnt + 6'd1;
    complete  = smp & (cnt_inc == n_bits);
    rx_pos    = lsb_i ? cnt[4:0] : n_m1 - cnt[4:0];
    rx_next   = rx_word;
    rx_next[rx_pos] = mosi_s2;
    word_n    = load ? (tx_valid_i ? tx_data_i : 32'd0) : tx_word;
    idx_n     = load ? 5'd0 : (shf ? cnt[4:0] : idx);
    tx_pos    = lsb_i ? idx_n : n_m1 - idx_n;
    // MISO is computed from next-cycle word/index so a new bit appears 1 clk after its edge.
    miso_n    = (start | (is_active & ~stop)) & word_n[tx_pos];
  end

  assign tx_ready_o    = load & tx_valid_i;
  assign busy_o        = (state == ACTIVE);
  assign spi_miso_en_o = (state == ACTIVE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      tx_word    <= 32'd0;
      rx_word    <= 32'd0;
      cnt        <= 6'd0;
      idx        <= 5'd0;
      done       <= 1'b0;
      rx_valid_o <= 1'b0;
      rx_data_o  <= 32'd0;
      udr_o      <= 1'b0;
      ovr_o      <= 1'b0;
      spi_miso_o <= 1'b0;
    end else begin
      udr_o      <= load & ~tx_valid_i;
      ovr_o      <= 1'b0;
      spi_miso_o <= miso_n;

      if (start)     state <= ACTIVE;
      else if (stop) state <= IDLE;

      if (stop) begin
        cnt     <= 6'd0;
        idx     <= 5'd0;
        done    <= 1'b0;
        rx_word <= 32'd0;
      end else if (load) begin
        tx_word <= word_n;
        cnt     <= 6'd0;
        idx     <= 5'd0;
        done    <= 1'b0;
        rx_word <= 32'd0;
      end else if (smp) begin
        if (complete) begin
          cnt     <= 6'd0;
          done    <= 1'b1;
          rx_word <= 32'd0;
        end else begin
          cnt     <= cnt_inc;
          rx_word <= rx_next;
        end
      end else if (shf) begin
        idx <= idx_n;
      end

      if (!en_i) begin
        rx_valid_o <= 1'b0;
      end else if (complete) begin
        if (rx_valid_o && !rx_ready_i) begin
          ovr_o <= 1'b1;
        end else begin
          rx_data_o  <= rx_next;
          rx_valid_o <= 1'b1;
        end
      end else if (rx_valid_o && rx_ready_i) begin
        rx_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_tgt_core.sv
// Bench for spi_tgt_core: a timed SPI master drives the pins, a tx feeder serves words,
// and a monitor checks delivered rx words against a queue filled by a transaction model.
module tb_spi_tgt_core;

  localparam int H = 6;

  logic        clk = 1'b0;
  logic        rst_i, en_i, cpol_i, cpha_i, lsb_i;
  logic [1:0]  dtb_i;
  logic        tx_valid_i, tx_ready_o;
  logic [31:0] tx_data_i;
  logic        rx_valid_o, rx_ready_i;
  logic [31:0] rx_data_o;
  logic        busy_o, udr_o, ovr_o;
  logic        spi_sck_i, spi_nss_i, spi_mosi_i, spi_miso_o, spi_miso_en_o;

  int checks = 0;
  int errors = 0;
  int n_udr = 0, n_ovr = 0, n_txr = 0;
  int exp_ovr = 0;
  bit model_pending = 0;
  logic [31:0] exp_q[$];
  logic [31:0] tx_q[$];
  logic [31:0] stock_q[$];
  logic [31:0] mosi_q[$];

  always #5 clk = ~clk;

  spi_tgt_core dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .cpol_i(cpol_i), .cpha_i(cpha_i),
    .lsb_i(lsb_i), .dtb_i(dtb_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
    .tx_data_i(tx_data_i), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
    .rx_data_o(rx_data_o), .busy_o(busy_o), .udr_o(udr_o), .ovr_o(ovr_o),
    .spi_sck_i(spi_sck_i), .spi_nss_i(spi_nss_i), .spi_mosi_i(spi_mosi_i),
    .spi_miso_o(spi_miso_o), .spi_miso_en_o(spi_miso_en_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // tx feeder and pulse counters
  initial begin
    tx_valid_i = 1'b0;
    tx_data_i  = 32'd0;
    forever begin
      @(negedge clk);
      tx_valid_i = (tx_q.size() > 0);
      tx_data_i  = tx_valid_i ? tx_q[0] : 32'd0;
      #3;
      if (tx_valid_i && tx_ready_o) begin
        void'(tx_q.pop_front());
        n_txr++;
      end
      if (udr_o) n_udr++;
      if (ovr_o) n_ovr++;
    end
  end

  // rx monitor
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (rx_valid_o && rx_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected actual=0x%08h required=none", rx_data_o);
        end else begin
          check("rx_data", rx_data_o, exp_q.pop_front());
        end
      end
    end
  end

  // Reference: a completed frame is either kept (pushed) or dropped when a word is still unread.
  task automatic model_rx(input logic [31:0] w);
    if (model_pending && !rx_ready_i) begin
      exp_ovr++;
    end else begin
      exp_q.push_back(w);
      if (!rx_ready_i) model_pending = 1'b1;
    end
  endtask

  task automatic drive_frame(input logic [31:0] mosi_w, input int n, input int nbits,
                             output logic [31:0] miso_w);
    int    pos;
    logic [31:0] w;
    w = mosi_w;
    miso_w = 32'd0;
    for (int i = 0; i < nbits; i++) begin
      pos = lsb_i ? i : n - 1 - i;
      if (!cpha_i) begin
        spi_mosi_i = w[pos];
        wait_clk(2);
        spi_sck_i = ~spi_sck_i;
        miso_w[pos] = spi_miso_o;
        if (i == n - 1) model_rx(w);
        wait_clk(H);
        spi_sck_i = ~spi_sck_i;
        wait_clk(H);
      end else begin
        spi_sck_i = ~spi_sck_i;
        spi_mosi_i = w[pos];
        wait_clk(H);
        spi_sck_i = ~spi_sck_i;
        miso_w[pos] = spi_miso_o;
        if (i == n - 1) model_rx(w);
        wait_clk(H);
      end
    end
  endtask

  task automatic session(input logic pol, input logic pha, input logic lsb, input logic [1:0] dtb,
                         input int frames, input int partial);
    int n, nl, nf, txr0, udr0, exp_txr, exp_udr;
    logic [63:0] m64;
    logic [31:0] mask, mw;
    logic [31:0] exp_tx[$];
    n   = 8 * (int'(dtb) + 1);
    m64 = (64'd1 << n) - 64'd1;
    mask = m64[31:0];
    nf  = frames + ((partial > 0) ? 1 : 0);
    // Word loads: one at NSS fall, then one at the first shift edge after each completed frame.
    if (pha) nl = (nf > 0) ? nf : 1;
    else     nl = 1 + frames;
    for (int k = 0; k < nl; k++) exp_tx.push_back((k < stock_q.size()) ? stock_q[k] : 32'd0);
    exp_txr = (nl < stock_q.size()) ? nl : stock_q.size();
    exp_udr = nl - exp_txr;
    txr0 = n_txr;
    udr0 = n_udr;
    @(negedge clk);
    tx_q = stock_q;
    cpol_i = pol; cpha_i = pha; lsb_i = lsb; dtb_i = dtb;
    spi_sck_i = pol;
    wait_clk(4);
    spi_nss_i = 1'b0;
    wait_clk(8);
    for (int f = 0; f < nf; f++) begin
      drive_frame(mosi_q[f] & mask, n, (f < frames) ? n : partial, mw);
      if (f < frames) check("miso_word", mw, exp_tx[f] & mask);
    end
    wait_clk(2);
    spi_nss_i = 1'b1;
    wait_clk(4);
    check("busy_after_nss", {31'd0, busy_o}, 32'd0);
    check("miso_en_after_nss", {31'd0, spi_miso_en_o}, 32'd0);
    wait_clk(6);
    check("tx_ready_pulses", n_txr - txr0, exp_txr);
    check("udr_pulses", n_udr - udr0, exp_udr);
    check("ovr_pulses", n_ovr, exp_ovr);
    tx_q.delete();
  endtask

  initial begin
    logic [31:0] mw;
    rst_i = 1'b1; en_i = 1'b1; cpol_i = 1'b0; cpha_i = 1'b0; lsb_i = 1'b0; dtb_i = 2'b00;
    rx_ready_i = 1'b1; spi_sck_i = 1'b0; spi_nss_i = 1'b1; spi_mosi_i = 1'b0;
    wait_clk(3);
    #1;
    check("reset_flags", {25'd0, busy_o, spi_miso_en_o, spi_miso_o, rx_valid_o, tx_ready_o, udr_o, ovr_o}, 32'd0);
    check("reset_rx_data", rx_data_o, 32'd0);
    @(negedge clk);
    rst_i = 1'b0;
    wait_clk(6);

    // mode 0, 8-bit MSB-first
    stock_q = '{32'h3C}; mosi_q = '{32'hA5};
    session(1'b0, 1'b0, 1'b0, 2'b00, 1, 0);
    // mode 3, 32-bit LSB-first
    stock_q = '{32'h12345678}; mosi_q = '{32'hDEADBEEF};
    session(1'b1, 1'b1, 1'b1, 2'b11, 1, 0);
    // mode 1, 16-bit, two frames under one NSS
    stock_q = '{32'hAAAA, 32'h5555}; mosi_q = '{$urandom, $urandom};
    session(1'b0, 1'b1, 1'b0, 2'b01, 2, 0);
    // no tx word at NSS fall
    stock_q.delete(); mosi_q = '{$urandom};
    session(1'b0, 1'b0, 1'b0, 2'b00, 1, 0);

    // consumer stalled across two frames
    rx_ready_i = 1'b0;
    stock_q = '{32'h5A, 32'hC3}; mosi_q = '{32'h11, 32'h22};
    session(1'b0, 1'b0, 1'b0, 2'b00, 2, 0);
    check("rx_valid_held", {31'd0, rx_valid_o}, 32'd1);
    check("rx_data_held", rx_data_o, 32'h11);
    rx_ready_i = 1'b1;
    model_pending = 1'b0;
    @(negedge clk);
    #3;
    check("rx_valid_drop", {31'd0, rx_valid_o}, 32'd0);

    // abort after 5 bits
    stock_q = '{32'h96}; mosi_q = '{$urandom};
    session(1'b0, 1'b0, 1'b0, 2'b00, 0, 5);
    check("abort_no_rx", {31'd0, rx_valid_o}, 32'd0);

    // reset in the middle of a frame, NSS held low across it
    @(negedge clk);
    cpol_i = 1'b0; cpha_i = 1'b0; lsb_i = 1'b0; dtb_i = 2'b00; spi_sck_i = 1'b0;
    tx_q = '{32'hF0};
    wait_clk(4);
    spi_nss_i = 1'b0;
    wait_clk(8);
    drive_frame(32'h6B, 8, 3, mw);
    rst_i = 1'b1;
    #1;
    check("midrst_flags", {25'd0, busy_o, spi_miso_en_o, spi_miso_o, rx_valid_o, tx_ready_o, udr_o, ovr_o}, 32'd0);
    wait_clk(3);
    #1;
    check("midrst_flags_hold", {25'd0, busy_o, spi_miso_en_o, spi_miso_o, rx_valid_o, tx_ready_o, udr_o, ovr_o}, 32'd0);
    @(negedge clk);
    rst_i = 1'b0;
    drive_frame(32'h6B, 8, 8, mw);
    check("midrst_stays_idle", {30'd0, busy_o, rx_valid_o}, 32'd0);
    wait_clk(2);
    spi_nss_i = 1'b1;
    wait_clk(10);
    tx_q.delete();
    exp_q.delete();
    exp_ovr = n_ovr;

    // recovery after reset
    stock_q = '{32'h81}; mosi_q = '{32'h7E};
    session(1'b1, 1'b0, 1'b1, 2'b00, 1, 0);

    // randomized sessions
    for (int s = 0; s < 8; s++) begin
      int ns;
      stock_q.delete();
      mosi_q.delete();
      ns = $urandom_range(0, 3);
      for (int k = 0; k < ns; k++) stock_q.push_back($urandom);
      for (int k = 0; k < 3; k++) mosi_q.push_back($urandom);
      session(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              2'($urandom_range(0, 3)), $urandom_range(1, 2), 0);
    end

    for (int i = 0; i < 200 && exp_q.size() > 0; i++) wait_clk(1);
    check("rx_queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
